// File: rtl/dht11_pkg.sv
// Shared types and constants for the DHT11 measurement sequencer.
// Status codes, FSM encoding, reading layout and the checksum helper live here.
package dht11_pkg;

  typedef enum logic [1:0] {
    ST_OK         = 2'b00,
    ST_CRC_FAIL   = 2'b01,
    ST_SENSOR_ERR = 2'b10,
    ST_TIMEOUT    = 2'b11
  } status_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GUARD = 3'd1,
    KICK  = 3'd2,
    WAIT  = 3'd3,
    CHECK = 3'd4,
    EVAL  = 3'd5,
    RESP  = 3'd6
  } state_e;

  typedef struct packed {
    logic [7:0] hum_int;
    logic [7:0] hum_frac;
    logic [7:0] temp_int;
    logic [7:0] temp_frac;
  } data_t;

  localparam int unsigned DEF_MIN_INTERVAL_CYC = 100_000_000;
  localparam int unsigned DEF_TIMEOUT_CYC      = 2_500_000;
  localparam int unsigned DEF_MAX_RETRY        = 2;

  // The DHT11 checksum is the plain 8-bit wrapping sum of the four data bytes.
  function automatic logic [7:0] dht_sum(input data_t d);
    return d.hum_int + d.hum_frac + d.temp_int + d.temp_frac;
  endfunction

endpackage

// File: rtl/dht11_measure_ctrl_if.sv
// Request, driver and response signals of the DHT11 measurement sequencer.
// req/rsp are valid/ready: a transfer happens on a rising CLK with valid and ready both high;
// the source holds valid and its payload stable until that transfer.
interface dht11_measure_ctrl_if;
  logic       req_valid;
  logic       req_ready;
  logic       dht_en;
  logic       dht_rst;
  logic       dht_done;
  logic       dht_error;
  logic [7:0] dht_hum_int;
  logic [7:0] dht_hum_frac;
  logic [7:0] dht_temp_int;
  logic [7:0] dht_temp_frac;
  logic [7:0] dht_crc;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [1:0] rsp_status;
  logic [7:0] rsp_hum_int;
  logic [7:0] rsp_hum_frac;
  logic [7:0] rsp_temp_int;
  logic [7:0] rsp_temp_frac;
  logic [1:0] rsp_attempts;

  modport slave (
    input  req_valid, dht_done, dht_error, dht_hum_int, dht_hum_frac,
           dht_temp_int, dht_temp_frac, dht_crc, rsp_ready,
    output req_ready, dht_en, dht_rst, rsp_valid, rsp_status, rsp_hum_int,
           rsp_hum_frac, rsp_temp_int, rsp_temp_frac, rsp_attempts
  );

  modport master (
    output req_valid, dht_done, dht_error, dht_hum_int, dht_hum_frac,
           dht_temp_int, dht_temp_frac, dht_crc, rsp_ready,
    input  req_ready, dht_en, dht_rst, rsp_valid, rsp_status, rsp_hum_int,
           rsp_hum_frac, rsp_temp_int, rsp_temp_frac, rsp_attempts
  );
endinterface

// File: rtl/dht11_interval_timer.sv
// Saturating up-counter with synchronous clear; reached_o is high once LIMIT cycles have elapsed.
// RST_SAT selects whether reset leaves the counter saturated (already reached) or at zero.
module dht11_interval_timer #(
  parameter int unsigned LIMIT   = 1,
  parameter bit          RST_SAT = 1'b0
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr_i,
  output logic reached_o
);
  localparam int unsigned W = ($clog2(LIMIT + 1) < 1) ? 1 : $clog2(LIMIT + 1);
  localparam logic [W-1:0] LIM = W'(LIMIT);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (cnt_q < LIM)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) cnt_q <= RST_SAT ? LIM : '0;
    else     cnt_q <= cnt_d;
  end

  assign reached_o = (cnt_q >= LIM);
endmodule

// File: rtl/dht11_measure_ctrl.sv
// DHT11 measurement sequencer: re-trigger guard, driver kick, timeout, checksum/error
// validation with bounded retries, and a status-tagged response.
module dht11_measure_ctrl
  import dht11_pkg::*;
#(
  parameter int unsigned MIN_INTERVAL_CYC = DEF_MIN_INTERVAL_CYC,
  parameter int unsigned TIMEOUT_CYC      = DEF_TIMEOUT_CYC,
  parameter int unsigned MAX_RETRY        = DEF_MAX_RETRY
) (
  input  logic                 CLK,
  input  logic                 RST,
  dht11_measure_ctrl_if.slave  bus,
  output state_e               state_o
);
  localparam logic [1:0] MAX_R = 2'(MAX_RETRY);

  state_e     state_q, state_d;
  logic       kick_ph_q, kick_ph_d;
  logic [1:0] retry_q, retry_d;
  status_e    fail_q, fail_d;
  data_t      cap_q, cap_d;
  logic [7:0] cap_crc_q, cap_crc_d;
  logic       cap_err_q, cap_err_d;
  data_t      rsp_q, rsp_d;
  status_e    status_q, status_d;
  logic [1:0] attempts_q, attempts_d;
  logic       guard_clr, guard_ok, to_hit;

  // Guard timer starts saturated so the first kick after reset is not delayed.
  dht11_interval_timer #(.LIMIT(MIN_INTERVAL_CYC), .RST_SAT(1'b1)) u_guard (
    .CLK(CLK), .RST(RST), .clr_i(guard_clr), .reached_o(guard_ok)
  );

  dht11_interval_timer #(.LIMIT(TIMEOUT_CYC - 1), .RST_SAT(1'b0)) u_timeout (
    .CLK(CLK), .RST(RST), .clr_i(state_q != WAIT), .reached_o(to_hit)
  );

  always_comb begin
    state_d       = state_q;
    kick_ph_d     = kick_ph_q;
    retry_d       = retry_q;
    fail_d        = fail_q;
    cap_d         = cap_q;
    cap_crc_d     = cap_crc_q;
    cap_err_d     = cap_err_q;
    rsp_d         = rsp_q;
    status_d      = status_q;
    attempts_d    = attempts_q;
    guard_clr     = 1'b0;
    bus.req_ready = 1'b0;
    bus.dht_en    = 1'b0;
    bus.dht_rst   = 1'b0;
    bus.rsp_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          retry_d = '0;
          state_d = GUARD;
        end
      end
      GUARD: begin
        if (guard_ok) begin
          guard_clr = 1'b1;
          kick_ph_d = 1'b0;
          state_d   = KICK;
        end
      end
      KICK: begin
        bus.dht_en  = 1'b1;
        bus.dht_rst = 1'b1;
        kick_ph_d   = 1'b1;
        if (kick_ph_q) state_d = WAIT;
      end
      WAIT: begin
        bus.dht_en = 1'b1;
        if (bus.dht_done) begin
          cap_d     = '{bus.dht_hum_int, bus.dht_hum_frac, bus.dht_temp_int, bus.dht_temp_frac};
          cap_crc_d = bus.dht_crc;
          cap_err_d = bus.dht_error;
          state_d   = CHECK;
        end else if (to_hit) begin
          fail_d  = ST_TIMEOUT;
          state_d = EVAL;
        end
      end
      CHECK: begin
        // An errored read carries zero data, which would pass the checksum.
        if (cap_err_q)                    fail_d = ST_SENSOR_ERR;
        else if (dht_sum(cap_q) != cap_crc_q) fail_d = ST_CRC_FAIL;
        else                              fail_d = ST_OK;
        state_d = EVAL;
      end
      EVAL: begin
        if (fail_q == ST_OK) begin
          rsp_d      = cap_q;
          status_d   = ST_OK;
          attempts_d = retry_q;
          state_d    = RESP;
        end else if (retry_q < MAX_R) begin
          retry_d = retry_q + 1'b1;
          state_d = GUARD;
        end else begin
          status_d   = fail_q;
          attempts_d = retry_q;
          state_d    = RESP;
        end
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      kick_ph_q  <= 1'b0;
      retry_q    <= '0;
      fail_q     <= ST_OK;
      cap_q      <= '0;
      cap_crc_q  <= '0;
      cap_err_q  <= 1'b0;
      rsp_q      <= '0;
      status_q   <= ST_OK;
      attempts_q <= '0;
    end else begin
      state_q    <= state_d;
      kick_ph_q  <= kick_ph_d;
      retry_q    <= retry_d;
      fail_q     <= fail_d;
      cap_q      <= cap_d;
      cap_crc_q  <= cap_crc_d;
      cap_err_q  <= cap_err_d;
      rsp_q      <= rsp_d;
      status_q   <= status_d;
      attempts_q <= attempts_d;
    end
  end

  assign bus.rsp_status    = status_q;
  assign bus.rsp_hum_int   = rsp_q.hum_int;
  assign bus.rsp_hum_frac  = rsp_q.hum_frac;
  assign bus.rsp_temp_int  = rsp_q.temp_int;
  assign bus.rsp_temp_frac = rsp_q.temp_frac;
  assign bus.rsp_attempts  = attempts_q;
  assign state_o           = state_q;
endmodule
